data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
// Parametrised data-memory controller between the core's load/store stage and an internal word RAM.
// Supports byte, half, word and (64-bit only) double accesses with little-endian lane select and
// sign/zero extension. Has a configurable wait-state count and a valid/ready handshake on both sides,
// so the pipeline can stall on memory. Drives the same wr/rd/addr/wr_data/rd_data debug taps as the core top.
// PARAMETERS
// DATA_W   32  word width in bits; legal values 32 or 64
// ADDR_W   9   byte-address width; RAM depth = 2**ADDR_W / (DATA_W/8) words
// LATENCY  2   wait cycles between request acceptance and commit; 0..15
// PORTS
// clk          in   1       clock, rising edge
// reset        in   1       asynchronous, active-low (0 = reset)
// req_valid    in   1       request present
// req_ready    out  1       controller can accept a request
// req_we       in   1       1 = store, 0 = load
// req_size     in   2       00 byte, 01 half, 10 word, 11 double
// req_unsigned in   1       1 = zero-extend load, 0 = sign-extend load
// req_addr     in   ADDR_W  byte address
// req_wdata    in   DATA_W  store data, right-aligned (LSBs)
// rsp_valid    out  1       response present
// rsp_ready    in   1       consumer takes the response
// rsp_rdata    out  DATA_W  extended load data; 0 for stores and errors
// rsp_err      out  1       misaligned or illegal-size access
// wr, rd       out  1       one-cycle pulse at commit of a store / load
// addr         out  ADDR_W  address of the committed access
// wr_data      out  DATA_W  raw req_wdata of the committed store
// rd_data      out  DATA_W  extended data of the committed load
// BEHAVIOUR
// - Reset: state=IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=0; wr=rd=0; addr=0; wr_data=rd_data=0.
//   RAM contents are not reset.
// - FSM states: IDLE, WAIT, RESP.
//   - IDLE: req_ready=1. On req_valid, latch we/size/unsigned/addr/wdata and load cnt=LATENCY.
//     Then go to WAIT if LATENCY>0; otherwise commit on that same edge and go to RESP.
//   - WAIT: req_ready=0. cnt decrements every cycle. On the cycle cnt==1, commit and go to RESP.
//     Acceptance-to-rsp_valid latency = LATENCY+1 cycles.
//   - RESP: rsp_valid=1; rsp_* held stable until rsp_ready=1. Then go to IDLE, with rsp_valid=0 on the next cycle.
//     req_ready=0 in RESP, so there is no back-to-back overlap; minimum spacing is LATENCY+2 cycles.
// - Commit:
//   - Check: illegal = (size==11 && DATA_W==32) | (half && a[0]) | (word && a[1:0]!=0) | (double && a[2:0]!=0).
//   - If illegal: rsp_err=1, RAM untouched, no wr/rd pulse.
//   - Word index = addr >> log2(DATA_W/8). Lane offset = addr mod (DATA_W/8) bytes.
//   - Store: write only the byte lanes covered by size at the offset; other bytes are preserved.
//     Pulse wr=1 for one cycle.
//   - Load: extract lanes at the offset, then sign-extend (bit 7/15/31) or zero-extend to DATA_W.
//     Write rsp_rdata and rd_data; pulse rd=1 for one cycle.
//   - addr/wr_data/rd_data hold their last committed values between commits.
// - Request inputs are ignored outside IDLE; the latched copies are used.
// - rsp_ready is ignored outside RESP.
// - Reset asserted mid-operation: abort immediately. A store not yet committed is never written.
//   rsp_valid drops asynchronously.
// - Addresses wrap naturally within ADDR_W; there is no out-of-range error.
// TESTING
// - Store word 0xDEADBEEF @0x10, then load word @0x10, LATENCY=2: rsp_valid 3 cycles after each accept; rdata=0xDEADBEEF; wr/rd pulse once each.
// - Store byte 0x80 @0x11, then load byte signed @0x11: 0xFFFFFF80; unsigned: 0x00000080; load word @0x10: 0xDEAD80EF.
// - Load half @0x13 and word @0x12: rsp_err=1, rdata=0, no rd pulse; the following aligned load still returns correct data.
// - Hold rsp_ready=0 for 5 cycles in RESP: rsp_valid/rdata stable, req_ready=0, new req_valid ignored; accept resumes after rsp_ready.
// - Drop reset in WAIT of store 0x12345678 @0x20: next load @0x20 returns prior contents; all outputs at reset values.
// - DATA_W=64, LATENCY=0: double store/load @0x08 round-trips with latency 1; size=11 with DATA_W=32 gives rsp_err=1.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: load/store controller for an internal word RAM with wait states,
// little-endian lane select, sign/zero extension and a valid/ready handshake on both sides.
module data_mem_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              wr,
  output logic              rd,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);
  localparam int NB    = DATA_W / 8;
  localparam int OW    = $clog2(NB);
  localparam int DEPTH = 2 ** (ADDR_W - OW);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  logic [1:0]          state, size_q, c_size;
  logic [3:0]          cnt;
  logic                we_q, uns_q, idle, commit, c_we, c_uns, illegal;
  logic [ADDR_W-1:0]   addr_q, c_addr;
  logic [DATA_W-1:0]   wdata_q, c_wdata, word, shifted, lmask, wmask, ext, new_word;
  logic [NB-1:0]       bmask, wbytes;
  logic [OW-1:0]       off;
  logic [ADDR_W-OW-1:0] idx;
  logic [DATA_W-1:0]   mem [DEPTH];
  assign idle      = state == IDLE;
  assign req_ready = idle;
  assign rsp_valid = state == RESP;
  // With zero wait states the live request commits on its acceptance edge.
  assign c_we    = idle ? req_we       : we_q;
  assign c_uns   = idle ? req_unsigned : uns_q;
  assign c_size  = idle ? req_size     : size_q;
  assign c_addr  = idle ? req_addr     : addr_q;
  assign c_wdata = idle ? req_wdata    : wdata_q;
  assign commit  = idle ? (req_valid && LATENCY == 0) : (state == WAIT && cnt == 4'd1);
  assign off     = c_addr[OW-1:0];
  assign idx     = c_addr[ADDR_W-1:OW];
  assign illegal = (c_size == 2'd3 && DATA_W == 32) || (c_size == 2'd1 && c_addr[0]) ||
                   (c_size == 2'd2 && c_addr[1:0] != 2'd0) || (c_size == 2'd3 && c_addr[2:0] != 3'd0);
  assign bmask   = NB'((32'd1 << (32'd1 << c_size)) - 32'd1);
  assign wbytes  = bmask << off;
  always_comb begin
    lmask = '0;
    wmask = '0;
    for (int i = 0; i < NB; i++) begin
      lmask[i*8 +: 8] = {8{bmask[i]}};
      wmask[i*8 +: 8] = {8{wbytes[i]}};
    end
  end
  assign word     = mem[idx];
  assign shifted  = word >> {off, 3'b0};
  // Sign bit is the top bit of the access mask.
  assign ext      = (shifted & lmask) |
                    ((!c_uns && |(shifted & lmask & ~(lmask >> 1))) ? ~lmask : '0);
  assign new_word = (word & ~wmask) | ((c_wdata << {off, 3'b0}) & wmask);
  always_ff @(posedge clk)
    if (reset && commit && c_we && !illegal) mem[idx] <= new_word;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      wr        <= 1'b0;
      rd        <= 1'b0;
      addr      <= '0;
      wr_data   <= '0;
      rd_data   <= '0;
    end else begin
      wr <= 1'b0;
      rd <= 1'b0;
      if (idle && req_valid) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        cnt     <= 4'(LATENCY);
        state   <= LATENCY == 0 ? RESP : WAIT;
      end else if (state == WAIT) begin
        cnt   <= cnt - 4'd1;
        state <= commit ? RESP : WAIT;
      end else if (state == RESP && rsp_ready) begin
        state <= IDLE;
      end
      if (commit) begin
        rsp_err   <= illegal;
        rsp_rdata <= (!illegal && !c_we) ? ext : '0;
        if (!illegal) begin
          addr <= c_addr;
          if (c_we) begin
            wr      <= 1'b1;
            wr_data <= c_wdata;
          end else begin
            rd      <= 1'b1;
            rd_data <= ext;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: scoreboard bench for a 32-bit/LATENCY=2 and a 64-bit/LATENCY=0 controller.
module tb_data_mem_ctrl;
  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;
  logic        sel = 1'b0, req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, rsp_ready = 1'b1;
  logic [1:0]  req_size = '0;
  logic [8:0]  req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        rq0, rv0, re0, wr0, rd0, rq1, rv1, re1, wr1, rd1;
  logic [8:0]  a0, a1;
  logic [31:0] rr0, wd0, rdd0;
  logic [63:0] rr1, wd1, rdd1;
  logic        rq, rv, re, wr, rd;
  logic [8:0]  ad;
  logic [63:0] rr, wd, rdd;
  int checks = 0, failures = 0;
  logic [64:0] sb[$];
  assign rq  = sel ? rq1 : rq0;
  assign rv  = sel ? rv1 : rv0;
  assign re  = sel ? re1 : re0;
  assign wr  = sel ? wr1 : wr0;
  assign rd  = sel ? rd1 : rd0;
  assign ad  = sel ? a1 : a0;
  assign rr  = sel ? rr1 : {32'b0, rr0};
  assign wd  = sel ? wd1 : {32'b0, wd0};
  assign rdd = sel ? rdd1 : {32'b0, rdd0};
  data_mem_ctrl #(.DATA_W(32), .ADDR_W(9), .LATENCY(2)) d0 (
    .clk(clk), .reset(reset), .req_valid(req_valid && !sel), .req_ready(rq0), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_rdata(rr0), .rsp_err(re0), .wr(wr0), .rd(rd0),
    .addr(a0), .wr_data(wd0), .rd_data(rdd0));
  data_mem_ctrl #(.DATA_W(64), .ADDR_W(9), .LATENCY(0)) d1 (
    .clk(clk), .reset(reset), .req_valid(req_valid && sel), .req_ready(rq1), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_rdata(rr1), .rsp_err(re1), .wr(wr1), .rd(rd1),
    .addr(a1), .wr_data(wd1), .rd_data(rdd1));
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask
  task automatic xact(input logic we, input logic [1:0] sz, input logic un, input logic [8:0] a,
                      input logic [63:0] wdat, input logic err, input logic [63:0] rdat, input int hold = 0);
    logic [64:0] e;
    int n = 0, wc = 0, rc = 0;
    sb.push_back({err, rdat});
    @(negedge clk);
    chk("req_ready", rq, 1);
    req_we = we; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wdat;
    req_valid = 1'b1;
    rsp_ready = (hold == 0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      wc += int'(wr);
      rc += int'(rd);
      if (rv) break;
    end
    chk("latency", 64'(n), sel ? 64'd1 : 64'd3);
    e = sb.pop_front();
    chk("rsp_err", re, e[64]);
    chk("rsp_rdata", rr, e[63:0]);
    if (!err) begin
      chk("addr_tap", ad, a);
      if (we) chk("wr_data", wd, wdat);
      else chk("rd_data", rdd, rdat);
    end
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 9'h40; req_wdata = '1;
      @(negedge clk);
      wc += int'(wr);
      rc += int'(rd);
      chk("hold_valid", rv, 1);
      chk("hold_rdata", rr, e[63:0]);
      chk("hold_ready", rq, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    wc += int'(wr);
    rc += int'(rd);
    chk("rsp_drop", rv, 0);
    chk("wr_pulses", 64'(wc), 64'(we && !err));
    chk("rd_pulses", 64'(rc), 64'(!we && !err));
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req_ready", rq, 1);
    chk("rst_rsp_valid", rv, 0);
    chk("rst_rsp_err", re, 0);
    chk("rst_rsp_rdata", rr, 0);
    chk("rst_taps", {wr, rd, ad, wd[31:0], rdd[31:0]}, 0);
    reset = 1'b1;
    xact(1, 2'd2, 0, 9'h10, 64'hDEADBEEF, 0, 0);
    xact(0, 2'd2, 0, 9'h10, 0, 0, 64'hDEADBEEF);
    xact(1, 2'd0, 0, 9'h11, 64'h80, 0, 0);
    xact(0, 2'd0, 0, 9'h11, 0, 0, 64'hFFFFFF80);
    xact(0, 2'd0, 1, 9'h11, 0, 0, 64'h00000080);
    xact(0, 2'd2, 0, 9'h10, 0, 0, 64'hDEAD80EF);
    xact(0, 2'd1, 0, 9'h13, 0, 1, 0);
    xact(0, 2'd2, 0, 9'h12, 0, 1, 0);
    xact(0, 2'd1, 1, 9'h12, 0, 0, 64'h0000DEAD);
    xact(0, 2'd1, 0, 9'h12, 0, 0, 64'hFFFFDEAD);
    xact(0, 2'd3, 0, 9'h10, 0, 1, 0);
    xact(1, 2'd2, 0, 9'h40, 64'h55AA1234, 0, 0);
    xact(0, 2'd2, 0, 9'h40, 0, 0, 64'h55AA1234, 5);
    xact(0, 2'd2, 0, 9'h40, 0, 0, 64'h55AA1234);
    xact(1, 2'd2, 0, 9'h20, 64'hAAAA5555, 0, 0);
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 9'h20; req_wdata = 64'h12345678;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_rsp_valid", rv, 0);
    chk("abort_req_ready", rq, 1);
    chk("abort_rsp", {re, rr}, 0);
    chk("abort_taps", {wr, rd, ad, wd[31:0], rdd[31:0]}, 0);
    repeat (2) @(negedge clk);
    chk("abort_no_wr", wr, 0);
    reset = 1'b1;
    xact(0, 2'd2, 0, 9'h20, 0, 0, 64'hAAAA5555);
    sel = 1'b1;
    xact(1, 2'd3, 0, 9'h08, 64'h0123456789ABCDEF, 0, 0);
    xact(0, 2'd3, 0, 9'h08, 0, 0, 64'h0123456789ABCDEF);
    xact(0, 2'd2, 0, 9'h08, 0, 0, 64'hFFFFFFFF89ABCDEF);
    xact(0, 2'd2, 1, 9'h0C, 0, 0, 64'h0000000001234567);
    xact(0, 2'd3, 0, 9'h0C, 0, 1, 0);
    xact(1, 2'd0, 0, 9'h0F, 64'h00000000000000FF, 0, 0);
    xact(0, 2'd3, 0, 9'h08, 0, 0, 64'hFF23456789ABCDEF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
